sequence_error_accumulator: RTL and testbench

- Downstream/evaluation stage for the chromosome circuit. It steps through the stored test sequences one at a time and publishes the index of the sequence the upstream mux must apply to the evolved circuit.
- After each sequence it waits a programmable settle time, then compares the circuit output with the expected output under the valid mask.
- It accumulates one per-output-bit mismatch count, and those counts are what the HPS reads back as error sums.
- Start/done handshake with the HPS is a PIO level handshake.

---
 rtl/sequence_error_accumulator.sv | 124 ++++++++++++
 tb/tb_sequence_error_accumulator.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sequence_error_accumulator.sv
// Steps through test sequences, waits a selectable settle time, then counts masked per-bit output mismatches.
// No stalls: DONE is entered 1+N*(L+1) cycles after iStart. iStall freezes SETTLE/ACCUM in place.
module sequence_error_accumulator #(
  parameter int NUM_OUTPUTS = 8,
  parameter int SUM_WIDTH   = 32,
  parameter int SEQ_WIDTH   = 8
) (
  input  logic                             iClock,
  input  logic                             iReset,
  input  logic                             iStart,
  input  logic                             iDoneProcessingFeedback,
  input  logic                             iStall,
  input  logic [SEQ_WIDTH-1:0]             iSequencesToProcess,
  input  logic [1:0]                       iClockChangeCyclesSelector,
  input  logic [NUM_OUTPUTS-1:0]           iCircuitOutput,
  input  logic [NUM_OUTPUTS-1:0]           iExpectedOutput,
  input  logic [NUM_OUTPUTS-1:0]           iValidOutput,
  output logic [SEQ_WIDTH-1:0]             oSeqIndex,
  output logic                             oReadyToProcess,
  output logic                             oDoneProcessing,
  output logic [NUM_OUTPUTS*SUM_WIDTH-1:0] oErrorSums,
  output logic [1:0]                       oState
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACCUM  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [SEQ_WIDTH-1:0] SEQ_ONE = SEQ_WIDTH'(1);
  localparam logic [SUM_WIDTH-1:0] SUM_ONE = SUM_WIDTH'(1);
  localparam logic [SUM_WIDTH-1:0] SUM_MAX = '1;

  state_t                 state_q, state_d;
  logic [SEQ_WIDTH-1:0]   seq_index_q;
  logic [SEQ_WIDTH-1:0]   seq_count_q;
  logic [1:0]             sel_q;
  logic [7:0]             settle_cnt_q;
  logic [SUM_WIDTH-1:0]   sums_q [NUM_OUTPUTS];
  logic                   ready_q;
  logic                   done_q;
  logic [NUM_OUTPUTS-1:0] hit;
  logic                   last_seq;

  // Counter holds L-1 so that SETTLE lasts exactly L unstalled cycles.
  function automatic logic [7:0] settle_reload(input logic [1:0] sel);
    case (sel)
      2'd0:    settle_reload = 8'd3;
      2'd1:    settle_reload = 8'd15;
      2'd2:    settle_reload = 8'd63;
      default: settle_reload = 8'd255;
    endcase
  endfunction

  assign hit      = iValidOutput & (iCircuitOutput ^ iExpectedOutput);
  assign last_seq = (seq_index_q == seq_count_q - SEQ_ONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (iStart) state_d = (iSequencesToProcess == '0) ? DONE : SETTLE;
      SETTLE:  if (!iStall && settle_cnt_q == 8'd0) state_d = ACCUM;
      ACCUM:   if (!iStall) state_d = last_seq ? DONE : SETTLE;
      DONE:    if (iDoneProcessingFeedback) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q      <= IDLE;
      seq_index_q  <= '0;
      seq_count_q  <= '0;
      sel_q        <= 2'd0;
      settle_cnt_q <= 8'd0;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
      for (int b = 0; b < NUM_OUTPUTS; b++) sums_q[b] <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == IDLE);
      done_q  <= (state_d == DONE);
      case (state_q)
        IDLE: begin
          if (iStart) begin
            seq_index_q  <= '0;
            seq_count_q  <= iSequencesToProcess;
            sel_q        <= iClockChangeCyclesSelector;
            settle_cnt_q <= settle_reload(iClockChangeCyclesSelector);
            for (int b = 0; b < NUM_OUTPUTS; b++) sums_q[b] <= '0;
          end
        end
        SETTLE: begin
          if (!iStall && settle_cnt_q != 8'd0) settle_cnt_q <= settle_cnt_q - 8'd1;
        end
        ACCUM: begin
          if (!iStall) begin
            // Saturate rather than wrap so a long run never reports a small sum.
            for (int b = 0; b < NUM_OUTPUTS; b++) begin
              if (hit[b] && sums_q[b] != SUM_MAX) sums_q[b] <= sums_q[b] + SUM_ONE;
            end
            if (!last_seq) begin
              seq_index_q  <= seq_index_q + SEQ_ONE;
              settle_cnt_q <= settle_reload(sel_q);
            end
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_sums
    assign oErrorSums[g*SUM_WIDTH +: SUM_WIDTH] = sums_q[g];
  end

  assign oSeqIndex       = seq_index_q;
  assign oReadyToProcess = ready_q;
  assign oDoneProcessing = done_q;
  assign oState          = state_q;

endmodule

// File: tb/tb_sequence_error_accumulator.sv
// Directed bench for sequence_error_accumulator: timing, masked error counting, stall, reset and handshake.
module tb_sequence_error_accumulator;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         feedback;
  logic         stall;
  logic [7:0]   seq_n;
  logic [1:0]   sel;
  logic [7:0]   circ;
  logic [7:0]   expd;
  logic [7:0]   valid;
  logic [7:0]   seq_index;
  logic         ready;
  logic         done;
  logic [255:0] sums;
  logic [1:0]   state;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  sequence_error_accumulator #(
    .NUM_OUTPUTS(8), .SUM_WIDTH(32), .SEQ_WIDTH(8)
  ) dut (
    .iClock(clk),
    .iReset(rst),
    .iStart(start),
    .iDoneProcessingFeedback(feedback),
    .iStall(stall),
    .iSequencesToProcess(seq_n),
    .iClockChangeCyclesSelector(sel),
    .iCircuitOutput(circ),
    .iExpectedOutput(expd),
    .iValidOutput(valid),
    .oSeqIndex(seq_index),
    .oReadyToProcess(ready),
    .oDoneProcessing(done),
    .oErrorSums(sums),
    .oState(state)
  );

  // Pulse iStart for one edge and count edges (the sampling edge included) until DONE is visible.
  task automatic run_to_done(input logic [7:0] n, input logic [1:0] s, output int cycles);
    @(negedge clk);
    seq_n = n; sel = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 1;
    while (state !== 2'd3 && cycles < 2000) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; feedback = 1'b0; stall = 1'b0;
    seq_n = 8'd0; sel = 2'd0; circ = 8'h00; expd = 8'h00; valid = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    total++; if (state !== 2'd0) $display("FAIL reset_state got %0d want 0", state); else passed++;
    total++; if (ready !== 1'b1) $display("FAIL reset_ready got %b want 1", ready); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    total++; if (seq_index !== 8'd0) $display("FAIL reset_index got %0d want 0", seq_index); else passed++;
    total++; if (sums !== 256'd0) $display("FAIL reset_sums got %h want 0", sums); else passed++;
  endtask

  task automatic test_clean_run();
    int cyc;
    circ = 8'h5A; expd = 8'h5A; valid = 8'hFF;
    run_to_done(8'd3, 2'd0, cyc);
    total++; if (cyc !== 16) $display("FAIL clean_latency got %0d want 16", cyc); else passed++;
    total++; if (sums !== 256'd0) $display("FAIL clean_sums got %h want 0", sums); else passed++;
    total++; if (seq_index !== 8'd2) $display("FAIL clean_index got %0d want 2", seq_index); else passed++;
    total++; if (done !== 1'b1 || ready !== 1'b0) $display("FAIL clean_flags got done=%b ready=%b want 1/0", done, ready); else passed++;
    @(negedge clk) feedback = 1'b1;
    @(posedge clk); #1 feedback = 1'b0;
  endtask

  task automatic test_bit_errors();
    int cyc;
    logic [31:0] want;
    // xor = 8F, masked by 81 leaves bits 0 and 7 counting once per sequence
    circ = 8'h0E; expd = 8'h81; valid = 8'h81;
    run_to_done(8'd4, 2'd1, cyc);
    total++; if (cyc !== 69) $display("FAIL bits_latency got %0d want 69", cyc); else passed++;
    for (int b = 0; b < 8; b++) begin
      want = (b == 0 || b == 7) ? 32'd4 : 32'd0;
      total++;
      if (sums[b*32 +: 32] !== want) $display("FAIL bits_sum%0d got %0d want %0d", b, sums[b*32 +: 32], want);
      else passed++;
    end
    total++; if (seq_index !== 8'd3) $display("FAIL bits_index got %0d want 3", seq_index); else passed++;
    @(negedge clk) feedback = 1'b1;
    @(posedge clk); #1 feedback = 1'b0;
    total++; if (sums[31:0] !== 32'd4) $display("FAIL bits_retained got %0d want 4", sums[31:0]); else passed++;
  endtask

  task automatic test_masked_and_ack();
    int cyc;
    circ = 8'hFF; expd = 8'h00; valid = 8'h00;
    run_to_done(8'd2, 2'd0, cyc);
    total++; if (cyc !== 11) $display("FAIL masked_latency got %0d want 11", cyc); else passed++;
    total++; if (sums !== 256'd0) $display("FAIL masked_sums got %h want 0", sums); else passed++;
    @(negedge clk) feedback = 1'b1;
    @(posedge clk); #1 feedback = 1'b0;
    total++; if (state !== 2'd0) $display("FAIL ack_state got %0d want 0", state); else passed++;
    total++; if (ready !== 1'b1 || done !== 1'b0) $display("FAIL ack_flags got ready=%b done=%b want 1/0", ready, done); else passed++;
    total++; if (sums !== 256'd0) $display("FAIL ack_sums got %h want 0", sums); else passed++;
  endtask

  task automatic test_stall();
    int cyc;
    circ = 8'h03; expd = 8'h01; valid = 8'hFF;
    @(negedge clk);
    seq_n = 8'd2; sel = 2'd0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 1;
    repeat (2) begin @(posedge clk); #1 cyc++; end
    total++; if (state !== 2'd1) $display("FAIL stall_in_settle got %0d want 1", state); else passed++;
    stall = 1'b1;
    repeat (10) begin @(posedge clk); #1 cyc++; end
    total++; if (state !== 2'd1) $display("FAIL stall_hold got %0d want 1", state); else passed++;
    stall = 1'b0;
    while (state !== 2'd3 && cyc < 2000) begin
      @(posedge clk); #1 cyc++;
    end
    total++; if (cyc !== 21) $display("FAIL stall_latency got %0d want 21", cyc); else passed++;
    total++; if (sums[63:32] !== 32'd2) $display("FAIL stall_sum1 got %0d want 2", sums[63:32]); else passed++;
    total++; if (sums[31:0] !== 32'd0) $display("FAIL stall_sum0 got %0d want 0", sums[31:0]); else passed++;
    @(negedge clk) feedback = 1'b1;
    @(posedge clk); #1 feedback = 1'b0;
  endtask

  task automatic test_zero_and_reset();
    int cyc;
    run_to_done(8'd0, 2'd2, cyc);
    total++; if (cyc !== 1) $display("FAIL zero_latency got %0d want 1", cyc); else passed++;
    total++; if (sums !== 256'd0) $display("FAIL zero_sums got %h want 0", sums); else passed++;
    // start while in DONE must be ignored
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    total++; if (state !== 2'd3 || done !== 1'b1) $display("FAIL done_start_ignored got state=%0d done=%b want 3/1", state, done); else passed++;
    @(negedge clk) feedback = 1'b1;
    @(posedge clk); #1 feedback = 1'b0;
    total++; if (state !== 2'd0) $display("FAIL zero_ack got %0d want 0", state); else passed++;
    circ = 8'hFF; expd = 8'h00; valid = 8'hFF;
    @(negedge clk);
    seq_n = 8'd2; sel = 2'd0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    total++; if (sums !== {8{32'd1}}) $display("FAIL midrun_sums got %h want all 1", sums); else passed++;
    total++; if (state !== 2'd1 || seq_index !== 8'd1) $display("FAIL midrun_pos got state=%0d idx=%0d want 1/1", state, seq_index); else passed++;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    total++; if (state !== 2'd0 || ready !== 1'b1) $display("FAIL midrst_state got state=%0d ready=%b want 0/1", state, ready); else passed++;
    total++; if (sums !== 256'd0) $display("FAIL midrst_sums got %h want 0", sums); else passed++;
    total++; if (seq_index !== 8'd0) $display("FAIL midrst_index got %0d want 0", seq_index); else passed++;
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_bit_errors();
    test_masked_and_ack();
    test_stall();
    test_zero_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
